// File: rtl/ctrl_pkg.sv
// Shared definitions for the interrupt front end: FSM encoding, default sizes
// and the fixed-priority encoder used to pick the granted line.
package ctrl_pkg;

  localparam int DEF_NUM_IRQ   = 4;
  localparam int DEF_HANDLER_W = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQUEST = 2'd1,
    IRQ_SERVICE = 2'd2
  } irqState_t;

  // Lowest set index wins; an all-zero vector yields 0.
  function automatic logic [4:0] lowestSet(input logic [15:0] vec);
    lowestSet = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) lowestSet = 5'(i);
    end
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Handshake and status bundle between the control unit (master) and the
// interrupt controller (slave).
interface interrupt_controller_if #(
  parameter int NUM_IRQ   = ctrl_pkg::DEF_NUM_IRQ,
  parameter int HANDLER_W = ctrl_pkg::DEF_HANDLER_W
);

  logic                 IntEnable;
  logic                 MaskWrite;
  logic [NUM_IRQ-1:0]   MaskData;
  logic                 IntAck;
  logic                 RetInt;
  logic                 InterruptIn;
  logic [HANDLER_W-1:0] InterruptHandler;
  logic [NUM_IRQ-1:0]   CLR;
  logic                 InService;
  logic [NUM_IRQ-1:0]   Pending;

  modport master (
    output IntEnable, MaskWrite, MaskData, IntAck, RetInt,
    input  InterruptIn, InterruptHandler, CLR, InService, Pending
  );

  modport slave (
    input  IntEnable, MaskWrite, MaskData, IntAck, RetInt,
    output InterruptIn, InterruptHandler, CLR, InService, Pending
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw request line, with an optional
// rising-edge detector on the synchronised value.
module irq_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic irqRaw,
  output logic syncOut,
  output logic riseOut
);

  logic sync1Q;
  logic sync2Q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1Q <= 1'b0;
      sync2Q <= 1'b0;
    end else begin
      sync1Q <= irqRaw;
      sync2Q <= sync1Q;
    end
  end

  assign syncOut = sync2Q;

  if (EDGE) begin : g_edge
    logic prevQ;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) prevQ <= 1'b0;
      else        prevQ <= sync2Q;
    end

    assign riseOut = sync2Q & ~prevQ;
  end else begin : g_level
    assign riseOut = 1'b0;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt front end: synchronise, latch pending, mask, pick the
// lowest index and run the request/ack/return handshake with the control FSM.
module interrupt_controller
  import ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = DEF_NUM_IRQ,
  parameter int                 HANDLER_W = DEF_HANDLER_W,
  parameter logic [NUM_IRQ-1:0] EDGE_SENS = {NUM_IRQ{1'b1}}
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] IRQ,
  interrupt_controller_if.slave bus
);

  logic [NUM_IRQ-1:0]   syncLevel;
  logic [NUM_IRQ-1:0]   riseEvent;
  logic [NUM_IRQ-1:0]   pendingQ;
  logic [NUM_IRQ-1:0]   pendingD;
  logic [NUM_IRQ-1:0]   maskQ;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   clrPulse;
  logic [HANDLER_W-1:0] handlerQ;
  logic [HANDLER_W-1:0] handlerD;
  logic                 requestOut;
  logic                 serviceOut;
  irqState_t            stateQ;
  irqState_t            stateD;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(.EDGE(EDGE_SENS[i])) u_sync (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .irqRaw  (IRQ[i]),
      .syncOut (syncLevel[i]),
      .riseOut (riseEvent[i])
    );
  end

  // Edge lines: a new edge beats a same-cycle clear. Level lines mirror sync2.
  assign pendingD = (EDGE_SENS & ((pendingQ & ~clrPulse) | riseEvent))
                  | (~EDGE_SENS & syncLevel);

  assign eligible = bus.IntEnable ? (pendingQ & maskQ) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pendingQ <= '0;
      maskQ    <= '0;
      handlerQ <= '0;
      stateQ   <= IRQ_IDLE;
    end else begin
      pendingQ <= pendingD;
      if (bus.MaskWrite) maskQ <= bus.MaskData;
      handlerQ <= handlerD;
      stateQ   <= stateD;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateD     = stateQ;
    handlerD   = handlerQ;
    clrPulse   = '0;
    requestOut = 1'b0;
    serviceOut = 1'b0;
    case (stateQ)
      IRQ_IDLE: begin
        if (|eligible) begin
          handlerD = HANDLER_W'(lowestSet(16'(eligible)));
          stateD   = IRQ_REQUEST;
        end
      end
      IRQ_REQUEST: begin
        requestOut = 1'b1;
        if (bus.IntAck) begin
          clrPulse = NUM_IRQ'(1) << handlerQ;
          stateD   = IRQ_SERVICE;
        end
      end
      IRQ_SERVICE: begin
        serviceOut = 1'b1;
        if (bus.RetInt) stateD = IRQ_IDLE;
      end
      default: stateD = IRQ_IDLE;
    endcase
  end

  assign bus.InterruptIn      = requestOut;
  assign bus.InterruptHandler = handlerQ;
  assign bus.CLR              = clrPulse;
  assign bus.InService        = serviceOut;
  assign bus.Pending          = pendingQ;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised multi-source interrupt front end for the multicycle control unit.
- Synchronises NUM_IRQ external request lines and latches edge-type events as pending.
- Applies a software mask and picks the highest-priority line (lowest index).
- Runs a request/acknowledge/return handshake with the control FSM, driving its InterruptIn, InterruptHandler and CLR inputs.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (1..16).
- HANDLER_W, 4, width of the InterruptHandler index output; must satisfy 2**HANDLER_W >= NUM_IRQ.
- EDGE_SENS, {NUM_IRQ{1'b1}}, per-line mode: bit=1 rising-edge latched, bit=0 level.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IRQ  in  NUM_IRQ  raw external requests, asynchronous to CLK.
- IntEnable  in  1  global enable from the control unit status.
- MaskWrite  in  1  load MaskData into the mask register this cycle.
- MaskData  in  NUM_IRQ  new mask; 1 = line enabled.
- IntAck  in  1  control FSM has entered its interrupt state and writes EPC this cycle.
- RetInt  in  1  control FSM completed a return-from-interrupt.
- InterruptIn  out  1  request to the control FSM.
- InterruptHandler  out  HANDLER_W  index of the granted line, zero-extended.
- CLR  out  NUM_IRQ  one-cycle one-hot pulse clearing the granted pending bit.
- InService  out  1  high while a handler is running.
- Pending  out  NUM_IRQ  current pending vector, for debug and status reads.

Behaviour:
- Reset (RST_N low, async): sync flops, pending, mask, state and latched index all go to 0. Outputs: InterruptIn=0, InterruptHandler=0, CLR=0, InService=0, Pending=0.
- Synchroniser: two flops per line.
  - Edge line: pending bit sets on a sync2 rising edge (sync2=1, previous sync2=0). It clears only through CLR.
  - Level line: pending bit = sync2 each cycle. CLR has no effect on it.
- Simultaneous edge event and CLR on the same bit: the set wins.
- Mask: registered. MaskWrite takes effect on the next cycle's eligibility. Eligible = Pending & mask, gated by IntEnable.
- State machine, 2-bit encoding IDLE=0, REQUEST=1, SERVICE=2; code 3 returns to IDLE.
  - IDLE: if eligible is nonzero, latch the lowest set index into InterruptHandler and go to REQUEST.
  - REQUEST: InterruptIn=1, held steady along with InterruptHandler. Mask or IntEnable changes do not withdraw the request. On IntAck: CLR=one-hot(index) for that cycle, go to SERVICE.
  - SERVICE: InterruptIn=0, InService=1. No new request is made, so there is no nesting. On RetInt go to IDLE; InService drops the next cycle.
  - IntAck outside REQUEST and RetInt outside SERVICE are ignored.
- Latency, edge line, IRQ rising before clock edge k:
  - sync1 at k, sync2 at k+1.
  - Pending set after edge k+2.
  - InterruptIn high after edge k+3.
- Back-to-back: from IDLE after RetInt, a still-eligible line is requested one cycle later.
- Level line:
  - The pending bit stays high while the source holds the line high.
  - The line is re-requested after RetInt if it is still asserted.
  - If it deasserts during SERVICE, no re-request is made.
- Index width: lines beyond NUM_IRQ do not exist. Upper InterruptHandler bits are 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants IRQ_IDLE, IRQ_REQUEST, IRQ_SERVICE;
  - default NUM_IRQ and HANDLER_W;
  - a priority-encode function returning the lowest set index.
- One sub-module, irq_sync_edge: a per-line 2-flop synchroniser plus rising-edge detector with an EDGE parameter. It is instantiated NUM_IRQ times by generate.
- Pending, mask and FSM stay in interrupt_controller.

Test Plan:
1. Mask=4'b1111, IntEnable=1; pulse IRQ[2] before edge k -> Pending[2]=1 after k+2; InterruptIn=1, InterruptHandler=2 after k+3; IntAck -> CLR=4'b0100 for one cycle, InService=1; RetInt -> IDLE, InterruptIn=0.
2. IRQ[3] and IRQ[1] rise in the same cycle -> index 1 granted first; after RetInt, index 3 is requested one cycle later with CLR=4'b1000 at its ack.
3. Mask=4'b1110, pulse IRQ[0] -> Pending[0]=1 but InterruptIn stays 0; then write Mask=4'b1111 -> InterruptIn=1 two cycles after the MaskWrite cycle, InterruptHandler=0.
4. EDGE_SENS=4'b0111, hold IRQ[3] high through the ack -> re-requested after RetInt; drop IRQ[3] during SERVICE -> no re-request, Pending[3]=0 three cycles after the drop.
5. New IRQ[2] edge lands on the same cycle as CLR[2] -> Pending[2] stays 1 and the line is re-requested after RetInt.
6. Drive RST_N low mid-REQUEST, asynchronous to CLK -> InterruptIn, InService, CLR and Pending are 0 immediately; after release, no request until a fresh edge arrives and the mask is rewritten.
